// File: rtl/down_counter_pkg.sv
// Shared constants for the loadable down counter: FSM state and mode encodings.
package down_counter_pkg;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/half_subtractor.sv
// One-bit half subtractor: Diff = A - B, Bout set when B exceeds A.
module half_subtractor (
    input  logic A,
    input  logic B,
    output logic Diff,
    output logic Bout
);

    assign Diff = A ^ B;
    assign Bout = ~A & B;

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with wrap and one-shot modes; the decrement comes from a
// ripple chain of half subtractors whose final borrow flags the zero crossing.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             En,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             Mode,
    output logic [WIDTH-1:0] Count,
    output logic             Borrow,
    output logic             Done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             state_q, state_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] bchain;
    logic             raw_borrow;

    for (genvar i = 0; i < WIDTH; i++) begin : g_sub
        if (i == 0) begin : g_first
            half_subtractor u_hs (
                .A    (count_q[i]),
                .B    (En),
                .Diff (diff[i]),
                .Bout (bchain[i])
            );
        end else begin : g_rest
            half_subtractor u_hs (
                .A    (count_q[i]),
                .B    (bchain[i-1]),
                .Diff (diff[i]),
                .Bout (bchain[i])
            );
        end
    end

    assign raw_borrow = bchain[WIDTH-1];

    always_comb begin
        count_d = count_q;
        state_d = state_q;
        done_d  = done_q;
        if (Load) begin
            count_d = LoadVal;
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else if (state_q == ST_HALT) begin
            done_d = 1'b1;
        end else if (raw_borrow && (Mode == MODE_ONESHOT)) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
        end else begin
            // With En=0 the chain passes Count through unchanged; at zero it wraps to all ones.
            count_d = diff;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
            state_q <= ST_RUN;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign Count  = count_q;
    assign Done   = done_q;
    assign Borrow = raw_borrow & (state_q == ST_RUN) & ~Load;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model.
module tb_down_counter;

    localparam int unsigned W = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         En = 1'b0;
    logic         Load = 1'b0;
    logic [W-1:0] LoadVal = '0;
    logic         Mode = 1'b0;
    logic [W-1:0] Count;
    logic         Borrow;
    logic         Done;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model state
    int m_cnt = 0;
    bit m_halt = 1'b0;

    typedef struct {
        logic         load;
        logic [W-1:0] lv;
        logic         en;
        logic         mode;
        logic [W-1:0] cnt;
        logic         bor;
        logic         done;
    } vec_t;

    vec_t tbl[$];

    down_counter #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .En      (En),
        .Load    (Load),
        .LoadVal (LoadVal),
        .Mode    (Mode),
        .Count   (Count),
        .Borrow  (Borrow),
        .Done    (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic l, input int lv, input logic e, input logic m,
                                input int c, input logic b, input logic d);
        vec_t v;
        v.load = l; v.lv = lv[W-1:0]; v.en = e; v.mode = m;
        v.cnt = c[W-1:0]; v.bor = b; v.done = d;
        return v;
    endfunction

    // Apply inputs at the falling edge, settle briefly before sampling.
    task automatic drive(input logic l, input logic [W-1:0] lv, input logic e, input logic m);
        @(negedge Clk);
        Load = l; LoadVal = lv; En = e; Mode = m;
        #1;
    endtask

    // Advance the model by one rising edge with the currently applied inputs.
    task automatic model_edge();
        if (Load) begin
            m_cnt  = int'(LoadVal);
            m_halt = 1'b0;
        end else if (!m_halt && En) begin
            if (m_cnt == 0) begin
                if (Mode) m_halt = 1'b1;
                else m_cnt = MAXV;
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        int exp_b;
        exp_b = (En && m_cnt == 0 && !m_halt && !Load) ? 1 : 0;
        chk({tag, "_count"}, int'(Count), m_cnt);
        chk({tag, "_borrow"}, int'(Borrow), exp_b);
        chk({tag, "_done"}, int'(Done), int'(m_halt));
    endtask

    initial begin
        // Wrap from reset
        for (int i = 0; i < 10; i++) begin
            int c;
            c = (8 - i) % 8;
            tbl.push_back(mk(0, 0, 1, 0, c, c == 0, 0));
        end
        // One-shot from 2
        tbl.push_back(mk(1, 2, 0, 1, 6, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1));
        // HALT exit via load with En high
        tbl.push_back(mk(1, 6, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 6, 0, 0));
        // Load beats En
        tbl.push_back(mk(1, 3, 1, 0, 5, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0));
        // Enable gaps
        tbl.push_back(mk(1, 4, 0, 0, 7, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0));
        // Mode flip while halted must not leave HALT
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1));

        // Reset state
        #12;
        chk("reset_count", int'(Count), 0);
        chk("reset_done", int'(Done), 0);
        @(negedge Clk);
        Rst = 1'b0;

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].mode);
            chk({tag, "_count"}, int'(Count), int'(tbl[i].cnt));
            chk({tag, "_borrow"}, int'(Borrow), int'(tbl[i].bor));
            chk({tag, "_done"}, int'(Done), int'(tbl[i].done));
        end

        // Async reset mid-count: reach Count=5 in RUN, then reset between edges
        drive(1, 5, 0, 0);
        drive(0, 0, 0, 0);
        chk("pre_rst_count", int'(Count), 5);
        Rst = 1'b1;
        #1;
        chk("async_rst_count", int'(Count), 0);
        chk("async_rst_done", int'(Done), 0);
        drive(0, 0, 1, 0);
        Rst = 1'b0;
        #1;
        chk("post_rst_borrow", int'(Borrow), 1);
        drive(0, 0, 1, 0);
        chk("post_rst_wrap", int'(Count), 7);

        // Async reset while halted
        drive(1, 0, 0, 1);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 1);
        chk("halt_done", int'(Done), 1);
        Rst = 1'b1;
        #1;
        chk("halt_rst_done", int'(Done), 0);
        chk("halt_rst_count", int'(Count), 0);
        drive(0, 0, 0, 0);
        Rst = 1'b0;
        m_cnt = 0;
        m_halt = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic l, e, m;
            logic [W-1:0] lv;
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 5) == 0) ? ~Mode : Mode;
            lv = W'($urandom);
            drive(l, lv, e, m);
            check_model($sformatf("rnd%0d", i));
            @(posedge Clk);
            model_edge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
